mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage between the EX/MEM pipeline register and writeback.
- Issues data-memory load/store requests, shifts store data and builds byte enables, and computes the load rmask.
- Stalls the front of the pipeline until the data port responds.
- Registers its results into the MEM/WB register, which supplies alu_out, pc, mdrreg_out, rmask and valid to writeback.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX/MEM entry valid
- in_pc  in  32  instruction PC
- in_alu_out  in  32  ALU result / effective address
- in_rs2  in  32  store source data
- in_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- in_mem_read  in  1  load instruction
- in_mem_write  in  1  store instruction
- mem_stall  out  1  hold all upstream stages and EX/MEM contents
- dmem_address  out  32  word-aligned address, {in_alu_out[31:2],2'b00}
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wdata  out  32  shifted store data
- dmem_byte_enable  out  4  write byte mask
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- out_valid  out  1  MEM/WB valid
- out_pc  out  32  registered pc
- out_alu_out  out  32  registered alu_out
- out_mdr  out  32  registered raw load word
- out_rmask  out  4  registered load byte mask
- out_misalign  out  1  registered misaligned-access flag
- perf_stall_cnt  out  32  count of cycles with mem_stall=1

Behaviour:
- Reset: the asynchronous rst clears state to IDLE and clears all out_* and perf_stall_cnt to 0.
  - dmem_read and dmem_write are forced to 0 while rst=1.
  - A request in flight is abandoned, and a later dmem_resp arriving in IDLE with no request is ignored.
- memop = in_valid & (in_mem_read | in_mem_write).
- Misalignment rule: w requires addr[1:0]=00; h/hu requires addr[0]=0. mis = memop & violation.
- Masks:
  - b/bu: mask = 0001<<addr[1:0].
  - h/hu: mask = 0011<<{addr[1],1'b0}.
  - w: mask = 1111.
  - rmask equals the mask for loads; dmem_byte_enable equals the mask for stores, else 0000.
- Store data: sb {4{rs2[7:0]}}, sh {2{rs2[15:0]}}, sw rs2.
- FSM states IDLE and BUSY.
  - IDLE: if memop & !mis, assert dmem_read/dmem_write combinationally this cycle. If dmem_resp is also 1, complete in the same cycle; otherwise go to BUSY.
  - BUSY: hold address, data, enables and request stable; inputs are stable because mem_stall=1. On dmem_resp=1, complete and go to IDLE.
- mem_stall = memop & !mis & !dmem_resp (either state).
- Completion (zero-wait case): out_* load on the same edge the response is sampled. Load latency is 1 cycle from dmem_resp.
- MEM/WB register update on each edge:
  - If mem_stall=0: out_valid<=in_valid, and out_pc/out_alu_out/out_rmask/out_misalign load from the stage.
  - out_mdr<=dmem_rdata on a load completion; otherwise out_mdr holds its value.
  - If mem_stall=1: out_valid<=0 (bubble); other out_* hold.
- Non-memory instructions and bubbles pass with 1-cycle latency and no stall. out_rmask=0000 for non-loads.
- Misaligned access:
  - No dmem request and no stall.
  - Passes with out_misalign=1 and out_rmask=0000.
- perf_stall_cnt increments every cycle mem_stall=1 and wraps 0xFFFFFFFF->0.
- Simultaneous rst and dmem_resp: rst wins and no output loads.
- Simultaneous in_mem_read and in_mem_write is illegal; the block treats it as a load.

Test Plan:
- lw, addr 0x100, resp after 3 cycles with rdata 0xDEADBEEF:
  - dmem_read=1 and address 0x100 are stable for 3 cycles; mem_stall=1 for 3 cycles; out_valid=0 for 3 cycles.
  - Then out_mdr=0xDEADBEEF, out_rmask=1111, out_valid=1, and perf_stall_cnt=3.
- sb, rs2 0x000000A5, addr 0x203, resp same cycle:
  - dmem_address 0x200, wdata 0xA5A5A5A5, byte_enable 1000, no stall.
- lh at addr 0x102 -> rmask 1100. lhu at addr 0x101 -> no request, out_misalign=1, out_rmask=0000.
- Back-to-back ADD, lw (resp after 2 cycles), ADD:
  - out_valid sequence 1,0,0,1,1.
  - The second ADD enters only after the lw completes; out_pc values are in order.
- Assert rst while in BUSY, then pulse dmem_resp after reset releases with in_valid=0:
  - dmem_read drops immediately on rst; all out_*=0; state IDLE; the stray resp is ignored; perf_stall_cnt=0.
- Preload perf_stall_cnt to 0xFFFFFFFF via stalls (force in sim), then one stall cycle -> counter wraps to 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of every signal crossing the mem_stage boundary except clock and reset.
// Groups: EX/MEM entry (in_*), data-memory port (dmem_*), MEM/WB register (out_*),
// plus the upstream stall line and the stall performance counter.
// Modports: slave = the stage itself, master = whatever drives the stage.
interface mem_stage_if;
    // EX/MEM entry
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_alu_out;
    logic [31:0] in_rs2;
    logic [2:0]  in_funct3;
    logic        in_mem_read;
    logic        in_mem_write;

    // Upstream hold
    logic        mem_stall;

    // Data-memory port
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    // MEM/WB register
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_alu_out;
    logic [31:0] out_mdr;
    logic [3:0]  out_rmask;
    logic        out_misalign;

    // Performance
    logic [31:0] perf_stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_alu_out, in_rs2, in_funct3, in_mem_read, in_mem_write,
        input  dmem_rdata, dmem_resp,
        output mem_stall,
        output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
        output out_valid, out_pc, out_alu_out, out_mdr, out_rmask, out_misalign,
        output perf_stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_alu_out, in_rs2, in_funct3, in_mem_read, in_mem_write,
        output dmem_rdata, dmem_resp,
        input  mem_stall,
        input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
        input  out_valid, out_pc, out_alu_out, out_mdr, out_rmask, out_misalign,
        input  perf_stall_cnt
    );
endinterface

// File: rtl/mem_stage.sv
// Purpose: memory-access pipeline stage; issues dmem loads/stores, builds byte
//          enables / load rmask, registers results into the MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops complete on the edge that samples dmem_resp.
// Backpressure: mem_stall holds all upstream stages while a legal access waits for dmem_resp.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   bus (slave)   - in_*  : EX/MEM entry (valid, pc, alu_out/address, rs2, funct3, read/write)
//                   dmem_*: word-aligned request, shifted store data, byte enables, read data/resp
//                   out_* : MEM/WB register (valid, pc, alu_out, raw load word, rmask, misalign)
//                   mem_stall, perf_stall_cnt
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Decode of the EX/MEM entry
    logic            w_memop;
    logic            w_is_load;
    logic            w_viol;
    logic            w_mis;
    logic            w_req;
    logic            w_done;
    logic            w_stall;
    logic [3:0]      w_mask;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_addr_aligned;

    // Request as driven onto the data port (before reset gating)
    logic            w_dm_read;
    logic            w_dm_write;
    logic [XLEN-1:0] w_dm_addr;
    logic [XLEN-1:0] w_dm_wdata;
    logic [3:0]      w_dm_be;

    // Request captured when entering BUSY so the port stays stable while waiting
    logic            r_req_read;
    logic            r_req_write;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_req_wdata;
    logic [3:0]      r_req_be;

    // MEM/WB register
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_alu_out;
    logic [XLEN-1:0] r_out_mdr;
    logic [3:0]      r_out_rmask;
    logic            r_out_misalign;
    logic [31:0]     r_perf_stall_cnt;

    // ------------------------------------------------------------------
    // Access decode: size-dependent mask, store replication, alignment.
    // funct3[2] only selects signed/unsigned extension, which happens in
    // writeback, so byte/half variants share a row. Reserved encodings
    // fall through to word behaviour.
    // ------------------------------------------------------------------
    always_comb begin
        w_viol    = 1'b0;
        w_mask    = 4'b1111;
        w_st_data = bus.in_rs2;
        case (bus.in_funct3)
            3'b000, 3'b100: begin
                w_mask    = 4'b0001 << bus.in_alu_out[1:0];
                w_st_data = {4{bus.in_rs2[7:0]}};
            end
            3'b001, 3'b101: begin
                w_viol    = bus.in_alu_out[0];
                w_mask    = 4'b0011 << {bus.in_alu_out[1], 1'b0};
                w_st_data = {2{bus.in_rs2[15:0]}};
            end
            default: begin
                w_viol    = |bus.in_alu_out[1:0];
            end
        endcase
    end

    assign w_memop        = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
    // Read wins if both read and write are set: the entry is treated as a load.
    assign w_is_load      = bus.in_mem_read;
    assign w_mis          = w_memop & w_viol;
    // A misaligned access never reaches memory and never stalls.
    assign w_req          = w_memop & ~w_viol;
    assign w_done         = w_req & bus.dmem_resp;
    assign w_stall        = w_req & ~bus.dmem_resp;
    assign w_addr_aligned = {bus.in_alu_out[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------
    // FSM: next state and data-port drive.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dm_read   = w_req & w_is_load;
        w_dm_write  = w_req & ~w_is_load;
        w_dm_addr   = w_addr_aligned;
        w_dm_wdata  = (w_req & ~w_is_load) ? w_st_data : '0;
        w_dm_be     = (w_req & ~w_is_load) ? w_mask : 4'b0000;
        case (r_state)
            IDLE: begin
                // Zero-wait responses complete without leaving IDLE.
                if (w_req && !bus.dmem_resp) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_dm_read  = r_req_read;
                w_dm_write = r_req_write;
                w_dm_addr  = r_req_addr;
                w_dm_wdata = r_req_wdata;
                w_dm_be    = r_req_be;
                if (bus.dmem_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_read  <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= 4'b0000;
        end else if (r_state == IDLE && w_state_nxt == BUSY) begin
            r_req_read  <= w_dm_read;
            r_req_write <= w_dm_write;
            r_req_addr  <= w_dm_addr;
            r_req_wdata <= w_dm_wdata;
            r_req_be    <= w_dm_be;
        end
    end

    // Requests are killed combinationally by reset so an abandoned access
    // cannot linger on the port.
    assign bus.dmem_read        = w_dm_read & ~rst;
    assign bus.dmem_write       = w_dm_write & ~rst;
    assign bus.dmem_address     = w_dm_addr;
    assign bus.dmem_wdata       = w_dm_wdata;
    assign bus.dmem_byte_enable = w_dm_be;
    assign bus.mem_stall        = w_stall;

    // ------------------------------------------------------------------
    // MEM/WB register. While stalled a bubble is inserted and the rest of
    // the entry holds. out_mdr only changes when a load actually completes,
    // so a stray dmem_resp with no request in flight is ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_alu_out  <= '0;
            r_out_mdr      <= '0;
            r_out_rmask    <= 4'b0000;
            r_out_misalign <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_out_valid    <= bus.in_valid;
                r_out_pc       <= bus.in_pc;
                r_out_alu_out  <= bus.in_alu_out;
                r_out_rmask    <= (w_req & w_is_load) ? w_mask : 4'b0000;
                r_out_misalign <= w_mis;
            end else begin
                r_out_valid    <= 1'b0;
            end
            if (w_done && w_is_load) begin
                r_out_mdr <= bus.dmem_rdata;
            end
        end
    end

    // Free-running stall counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_alu_out    = r_out_alu_out;
    assign bus.out_mdr        = r_out_mdr;
    assign bus.out_rmask      = r_out_rmask;
    assign bus.out_misalign   = r_out_misalign;
    assign bus.perf_stall_cnt = r_perf_stall_cnt;

endmodule
